// File: rtl/delay_measure.sv
// Round-trip latency probe: emits PATTERN for one cycle, then counts cycles until
// the same word returns on din, or reports a timeout after MAX_CYCLES.
module delay_measure #(
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] PATTERN     = 32'hA5A5_5A5A,
    parameter int          MAX_CYCLES  = 1024,
    parameter int          COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   start,
    output logic [DATA_WIDTH-1:0]  dout,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   din_valid,
    output logic [COUNT_WIDTH-1:0] latency,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout
);

    typedef enum logic [2:0] {IDLE, SEND, WAIT, DONE, TMO} state_t;

    localparam logic [DATA_WIDTH-1:0]  PROBE = DATA_WIDTH'(PATTERN);
    localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(MAX_CYCLES);

    state_t                 state;
    state_t                 state_nxt;
    logic [COUNT_WIDTH-1:0] count;
    logic                   active;
    logic                   accept;
    logic                   match;
    logic                   expire;

    assign active = (state == SEND) || (state == WAIT);
    assign accept = start && en && !active;
    assign match  = active && din_valid && (din == PROBE);
    assign expire = (state == WAIT) && (count == LIMIT);

    // NOTE: next-state is defaulted to the current state before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, TMO: if (accept) state_nxt = SEND;
            SEND, WAIT: begin
                // Dropping enable aborts even if the probe returns in the same cycle.
                if (!en)              state_nxt = IDLE;
                else if (match)       state_nxt = DONE;
                else if (expire)      state_nxt = TMO;
                else if (state == SEND) state_nxt = WAIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            latency <= '0;
        end else begin
            state <= state_nxt;

            if (accept)
                count <= '0;
            else if (active && (count != '1))
                count <= count + 1'b1;

            if (active && en) begin
                if (match)
                    latency <= count;
                else if (expire)
                    latency <= '1;
            end
        end
    end

    assign dout    = (state == SEND) ? PROBE : '0;
    assign busy    = active;
    assign done    = (state == DONE);
    assign timeout = (state == TMO);

endmodule

// File: tb/tb_delay_measure.sv
// Directed bench for delay_measure: a bench-side delay line (zero, loopback or
// N-register tap) returns dout to din; expected latencies are hand-computed.
module tb_delay_measure;

    localparam int          DW  = 32;
    localparam int          CW  = 16;
    localparam logic [31:0] PAT = 32'hA5A5_5A5A;

    typedef enum {M_ZERO, M_LOOP, M_DLY} mode_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          start;
    logic [DW-1:0] dout;
    logic [DW-1:0] din;
    wire logic     din_valid = 1'b1;
    logic [CW-1:0] latency;
    logic          busy;
    logic          done;
    logic          timeout;

    mode_t         mode;
    int            dly;
    logic          flush;
    logic [DW-1:0] pipe [8];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc;

    delay_measure #(
        .DATA_WIDTH (DW),
        .PATTERN    (PAT),
        .MAX_CYCLES (8),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .start    (start),
        .dout     (dout),
        .din      (din),
        .din_valid(din_valid),
        .latency  (latency),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    // Delay under test: pipe[k] holds dout from k+1 cycles ago.
    always @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < 8; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= dout;
            for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_comb begin
        din = '0;
        if (mode == M_LOOP)     din = dout;
        else if (mode == M_DLY) din = pipe[dly-1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input mode_t m, input int d);
        mode  = m;
        dly   = d;
        flush = 1'b1;
    endtask

    // Accept a start, check the SEND cycle, then count busy cycles until the block settles.
    task automatic go(output int busy_cycles);
        start = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("send_dout", dout, PAT);
        check("send_done", done, 1'b0);
        check("send_tmo", timeout, 1'b0);
        busy_cycles = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            busy_cycles++;
            tick();
        end
        check("busy_bound", busy, 1'b0);
        check("idle_dout", dout, '0);
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        start = 1'b0;
        setup(M_ZERO, 1);
        tick();
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tmo", timeout, 1'b0);
        check("rst_lat", latency, 32'd0);
        check("rst_dout", dout, '0);

        en = 1'b1;

        // 3-register delay
        setup(M_DLY, 3);
        go(cyc);
        check("d3_busy_cycles", cyc, 32'd4);
        check("d3_lat", latency, 32'd3);
        check("d3_done", done, 1'b1);
        check("d3_tmo", timeout, 1'b0);

        // Combinational loopback
        setup(M_LOOP, 1);
        go(cyc);
        check("loop_busy_cycles", cyc, 32'd1);
        check("loop_lat", latency, 32'd0);
        check("loop_done", done, 1'b1);

        // Nothing returns: timeout after 8 WAIT cycles
        setup(M_ZERO, 1);
        go(cyc);
        check("tmo_busy_cycles", cyc, 32'd9);
        check("tmo_flag", timeout, 1'b1);
        check("tmo_lat", latency, 32'hFFFF);
        check("tmo_done", done, 1'b0);
        tick();
        check("tmo_hold", timeout, 1'b1);

        // start in WAIT is ignored
        setup(M_DLY, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", busy, 1'b1);
        check("restart_dout", dout, '0);
        for (int i = 0; i < 20 && busy; i++) tick();
        check("restart_lat", latency, 32'd5);
        check("restart_done", done, 1'b1);

        // en dropped in WAIT aborts, latency kept
        setup(M_DLY, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        tick();
        tick();
        en = 1'b0;
        tick();
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_tmo", timeout, 1'b0);
        check("abort_lat", latency, 32'd5);
        repeat (6) tick();
        check("abort_late_lat", latency, 32'd5);
        check("abort_late_done", done, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_no_en", busy, 1'b0);
        en = 1'b1;

        // reset mid-measurement
        setup(M_DLY, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_tmo", timeout, 1'b0);
        check("midrst_lat", latency, 32'd0);
        check("midrst_dout", dout, '0);
        repeat (6) tick();
        check("midrst_late_busy", busy, 1'b0);
        check("midrst_late_done", done, 1'b0);
        check("midrst_late_lat", latency, 32'd0);

        // back-to-back: 2 then 7
        setup(M_DLY, 2);
        go(cyc);
        check("b2b_lat2", latency, 32'd2);
        check("b2b_done2", done, 1'b1);
        setup(M_DLY, 7);
        go(cyc);
        check("b2b_busy7", cyc, 32'd8);
        check("b2b_lat7", latency, 32'd7);
        check("b2b_done7", done, 1'b1);
        check("b2b_tmo7", timeout, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
